// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
//
// Shared constants and types for the RTC display path.
//   - 7-bit ASCII codes used to paint the character grid
//   - Grid geometry (ROWS x COLS) and the derived row/column index widths
//   - Row index constants naming what each grid row shows
//   - glyph_sel_t: stage-1 result of the layout decode, either a BCD nibble
//     still to be converted or a ready-made literal character
// ---------------------------------------------------------------------------
package rtc_pkg;

    // ASCII codes (7-bit; the renderer has no use for the 8th bit)
    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_COLON = 7'h3A;
    localparam logic [6:0] ASCII_SLASH = 7'h2F;
    localparam logic [6:0] ASCII_QMARK = 7'h3F;
    localparam logic [6:0] ASCII_ZERO  = 7'h30;
    localparam logic [6:0] ASCII_A     = 7'h41;
    localparam logic [6:0] ASCII_P     = 7'h50;
    localparam logic [6:0] ASCII_M     = 7'h4D;
    localparam logic [6:0] ASCII_C     = 7'h43;
    localparam logic [6:0] ASCII_R     = 7'h52;
    localparam logic [6:0] ASCII_O     = 7'h4F;
    localparam logic [6:0] ASCII_N     = 7'h4E;

    // Grid geometry
    localparam int ROWS  = 4;
    localparam int COLS  = 16;
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    // What each grid row shows
    localparam logic [ROW_W-1:0] ROW_TIME  = 2'd0;
    localparam logic [ROW_W-1:0] ROW_DATE  = 2'd1;
    localparam logic [ROW_W-1:0] ROW_CRONO = 2'd2;
    localparam logic [ROW_W-1:0] ROW_BLANK = 2'd3;

    // Stage-1 decode result: when is_digit is set, nibble is converted to
    // ASCII in stage 2; otherwise literal is passed straight through.
    typedef struct packed {
        logic       is_digit;
        logic [3:0] nibble;
        logic [6:0] literal;
    } glyph_sel_t;

    // Build a selection that defers to the BCD converter
    function automatic glyph_sel_t digit_sel(input logic [3:0] n);
        glyph_sel_t s;
        s.is_digit = 1'b1;
        s.nibble   = n;
        s.literal  = ASCII_SPACE;
        return s;
    endfunction

    // Build a selection carrying a fixed character
    function automatic glyph_sel_t lit_sel(input logic [6:0] c);
        glyph_sel_t s;
        s.is_digit = 1'b0;
        s.nibble   = 4'd0;
        s.literal  = c;
        return s;
    endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// ---------------------------------------------------------------------------
// bcd_to_ascii
//
// Combinational conversion of one BCD nibble to its ASCII digit. Nibbles
// outside 0..9 (corrupt or uninitialised RTC registers) are shown as '?'
// so a bad value is visible on screen instead of an odd glyph.
//
// Ports
//   nibble  in  4  BCD digit
//   ascii   out 7  ASCII code ('0'..'9' or '?')
// ---------------------------------------------------------------------------
module bcd_to_ascii
    import rtc_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] ascii
);

    always_comb begin
        ascii = ASCII_QMARK;
        if (nibble <= 4'd9) begin
            ascii = ASCII_ZERO + {3'b000, nibble};
        end
    end

endmodule

// File: rtl/rtc_display_formatter.sv
// ---------------------------------------------------------------------------
// rtc_display_formatter
//
// Takes a snapshot of the RTC sequencer's BCD registers on a load strobe and
// serves it to the VGA text renderer as a 4x16 ASCII grid through a two-stage
// lookup pipeline (one request per cycle, fixed 2-cycle latency). Also owns
// the colon blink phase and a latched chronometer-expiry alarm.
//
// Grid layout
//   row 0  "HH:MM:SS XM"     colons follow blink, AM/PM only in 12h format
//   row 1  "DD/MM/YY"
//   row 2  "CRONO HH:MM:SS"  whole row blank while alarm=1 and blink=0
//   row 3  blank
//
// Parameters
//   BLINK_DIV  clock cycles per blink-phase toggle (>= 2)
//
// Ports
//   clock, reset                system clock, synchronous active-high reset
//   load                        capture all time/date/crono inputs
//   hora,min,seg,dia,mes,year   packed BCD time and date
//   horacrono,mincrono,segcrono packed BCD chronometer
//   AmPm, format                1 = PM, 1 = 12-hour display
//   char_req,char_row,char_col  lookup request
//   alarm_ack                   clears the alarm latch
//   char_code, char_valid       lookup result, 2 cycles after the request
//   alarm                       chronometer expired (latched)
//   blink                       current blink phase
// ---------------------------------------------------------------------------
module rtc_display_formatter
    import rtc_pkg::*;
#(
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [7:0]       hora,
    input  logic [7:0]       min,
    input  logic [7:0]       seg,
    input  logic [7:0]       dia,
    input  logic [7:0]       mes,
    input  logic [7:0]       year,
    input  logic [7:0]       horacrono,
    input  logic [7:0]       mincrono,
    input  logic [7:0]       segcrono,
    input  logic             AmPm,
    input  logic             format,
    input  logic             char_req,
    input  logic [ROW_W-1:0] char_row,
    input  logic [COL_W-1:0] char_col,
    input  logic             alarm_ack,
    output logic [6:0]       char_code,
    output logic             char_valid,
    output logic             alarm,
    output logic             blink
);

    localparam int               CNT_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    // Blink state
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_q, blink_d;

    // Snapshot registers
    logic [7:0] hora_q, hora_d;
    logic [7:0] min_q, min_d;
    logic [7:0] seg_q, seg_d;
    logic [7:0] dia_q, dia_d;
    logic [7:0] mes_q, mes_d;
    logic [7:0] year_q, year_d;
    logic [7:0] horacrono_q, horacrono_d;
    logic [7:0] mincrono_q, mincrono_d;
    logic [7:0] segcrono_q, segcrono_d;
    logic       am_pm_q, am_pm_d;
    logic       format_q, format_d;

    // Alarm latch
    logic alarm_q, alarm_d;
    logic alarm_set;

    // Pipeline
    glyph_sel_t sel;
    glyph_sel_t s1_sel_q, s1_sel_d;
    logic       s1_valid_q, s1_valid_d;
    logic [6:0] digit_ascii;
    logic [6:0] char_code_q, char_code_d;
    logic       char_valid_q, char_valid_d;

    // Free-running blink divider: the phase flips each time the counter wraps.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
        if (blink_cnt_q == CNT_MAX) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    // Snapshot capture. The hours tens nibble only ever needs 0..2, and bit 7
    // is used by some RTCs as a 12/24 flag, so it is cleared on capture.
    always_comb begin
        hora_d      = hora_q;
        min_d       = min_q;
        seg_d       = seg_q;
        dia_d       = dia_q;
        mes_d       = mes_q;
        year_d      = year_q;
        horacrono_d = horacrono_q;
        mincrono_d  = mincrono_q;
        segcrono_d  = segcrono_q;
        am_pm_d     = am_pm_q;
        format_d    = format_q;
        if (load) begin
            hora_d      = hora & 8'h7F;
            min_d       = min;
            seg_d       = seg;
            dia_d       = dia;
            mes_d       = mes;
            year_d      = year;
            horacrono_d = horacrono;
            mincrono_d  = mincrono;
            segcrono_d  = segcrono;
            am_pm_d     = AmPm;
            format_d    = format;
        end
    end

    // Alarm fires only on the transition nonzero -> 00:00:00, so reloading a
    // chronometer that is already at zero does not re-arm it. A set in the
    // same cycle as an acknowledge must not be lost, so set has priority.
    always_comb begin
        alarm_set = load
                  && (|{horacrono_q, mincrono_q, segcrono_q})
                  && !(|{horacrono, mincrono, segcrono});
        alarm_d = alarm_q;
        if (alarm_ack) begin
            alarm_d = 1'b0;
        end
        if (alarm_set) begin
            alarm_d = 1'b1;
        end
    end

    // Stage-1 layout decode. Blink and alarm are consumed here so an
    // in-flight lookup is immune to a phase change during stage 2.
    always_comb begin
        sel = lit_sel(ASCII_SPACE);
        case (char_row)
            ROW_TIME: begin
                case (char_col)
                    4'd0:       sel = digit_sel(hora_q[7:4]);
                    4'd1:       sel = digit_sel(hora_q[3:0]);
                    4'd2, 4'd5: sel = lit_sel(blink_q ? ASCII_COLON : ASCII_SPACE);
                    4'd3:       sel = digit_sel(min_q[7:4]);
                    4'd4:       sel = digit_sel(min_q[3:0]);
                    4'd6:       sel = digit_sel(seg_q[7:4]);
                    4'd7:       sel = digit_sel(seg_q[3:0]);
                    4'd9: begin
                        if (format_q) begin
                            sel = lit_sel(am_pm_q ? ASCII_P : ASCII_A);
                        end
                    end
                    4'd10: begin
                        if (format_q) begin
                            sel = lit_sel(ASCII_M);
                        end
                    end
                    default:    sel = lit_sel(ASCII_SPACE);
                endcase
            end
            ROW_DATE: begin
                case (char_col)
                    4'd0:       sel = digit_sel(dia_q[7:4]);
                    4'd1:       sel = digit_sel(dia_q[3:0]);
                    4'd2, 4'd5: sel = lit_sel(ASCII_SLASH);
                    4'd3:       sel = digit_sel(mes_q[7:4]);
                    4'd4:       sel = digit_sel(mes_q[3:0]);
                    4'd6:       sel = digit_sel(year_q[7:4]);
                    4'd7:       sel = digit_sel(year_q[3:0]);
                    default:    sel = lit_sel(ASCII_SPACE);
                endcase
            end
            ROW_CRONO: begin
                // Expired chronometer: the row flashes by blanking on blink=0
                if (!(alarm_q && !blink_q)) begin
                    case (char_col)
                        4'd0:        sel = lit_sel(ASCII_C);
                        4'd1:        sel = lit_sel(ASCII_R);
                        4'd2:        sel = lit_sel(ASCII_O);
                        4'd3:        sel = lit_sel(ASCII_N);
                        4'd4:        sel = lit_sel(ASCII_O);
                        4'd6:        sel = digit_sel(horacrono_q[7:4]);
                        4'd7:        sel = digit_sel(horacrono_q[3:0]);
                        4'd8, 4'd11: sel = lit_sel(ASCII_COLON);
                        4'd9:        sel = digit_sel(mincrono_q[7:4]);
                        4'd10:       sel = digit_sel(mincrono_q[3:0]);
                        4'd12:       sel = digit_sel(segcrono_q[7:4]);
                        4'd13:       sel = digit_sel(segcrono_q[3:0]);
                        default:     sel = lit_sel(ASCII_SPACE);
                    endcase
                end
            end
            ROW_BLANK: sel = lit_sel(ASCII_SPACE);
            default:   sel = lit_sel(ASCII_SPACE);
        endcase
    end

    // Stage-1 register inputs
    always_comb begin
        s1_valid_d = char_req;
        s1_sel_d   = sel;
    end

    bcd_to_ascii u_bcd_to_ascii (
        .nibble (s1_sel_q.nibble),
        .ascii  (digit_ascii)
    );

    // Stage 2: resolve the final code. The output holds its last value on
    // idle cycles so the renderer never sees a spurious glyph.
    always_comb begin
        char_valid_d = s1_valid_q;
        char_code_d  = char_code_q;
        if (s1_valid_q) begin
            char_code_d = s1_sel_q.is_digit ? digit_ascii : s1_sel_q.literal;
        end
    end

    // All state, including the pipeline, is cleared by reset so no request
    // issued before reset can surface afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            hora_q       <= 8'h00;
            min_q        <= 8'h00;
            seg_q        <= 8'h00;
            dia_q        <= 8'h00;
            mes_q        <= 8'h00;
            year_q       <= 8'h00;
            horacrono_q  <= 8'h00;
            mincrono_q   <= 8'h00;
            segcrono_q   <= 8'h00;
            am_pm_q      <= 1'b0;
            format_q     <= 1'b0;
            alarm_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_sel_q     <= lit_sel(ASCII_SPACE);
            char_valid_q <= 1'b0;
            char_code_q  <= ASCII_SPACE;
        end else begin
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            hora_q       <= hora_d;
            min_q        <= min_d;
            seg_q        <= seg_d;
            dia_q        <= dia_d;
            mes_q        <= mes_d;
            year_q       <= year_d;
            horacrono_q  <= horacrono_d;
            mincrono_q   <= mincrono_d;
            segcrono_q   <= segcrono_d;
            am_pm_q      <= am_pm_d;
            format_q     <= format_d;
            alarm_q      <= alarm_d;
            s1_valid_q   <= s1_valid_d;
            s1_sel_q     <= s1_sel_d;
            char_valid_q <= char_valid_d;
            char_code_q  <= char_code_d;
        end
    end

    assign char_code  = char_code_q;
    assign char_valid = char_valid_q;
    assign alarm      = alarm_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_rtc_display_formatter.sv
// ---------------------------------------------------------------------------
// tb_rtc_display_formatter
//
// Directed bench for rtc_display_formatter with BLINK_DIV=4 (blink phase
// flips every 4 cycles). Expected grid contents are written out as strings
// per row; colon cells and crono-row cells are resolved against the blink
// phase and alarm state at the cycle the request is issued.
// ---------------------------------------------------------------------------
module tb_rtc_display_formatter;
    import rtc_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] hora, min, seg, dia, mes, year;
    logic [7:0] horacrono, mincrono, segcrono;
    logic       AmPm, format;
    logic       char_req;
    logic [1:0] char_row;
    logic [3:0] char_col;
    logic       alarm_ack;
    logic [6:0] char_code;
    logic       char_valid;
    logic       alarm;
    logic       blink;

    always #5 clock = ~clock;

    rtc_display_formatter #(.BLINK_DIV(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .hora       (hora),
        .min        (min),
        .seg        (seg),
        .dia        (dia),
        .mes        (mes),
        .year       (year),
        .horacrono  (horacrono),
        .mincrono   (mincrono),
        .segcrono   (segcrono),
        .AmPm       (AmPm),
        .format     (format),
        .char_req   (char_req),
        .char_row   (char_row),
        .char_col   (char_col),
        .alarm_ack  (alarm_ack),
        .char_code  (char_code),
        .char_valid (char_valid),
        .alarm      (alarm),
        .blink      (blink)
    );

    // kind 0: fixed code, 1: blinking colon, 2: crono row subject to flash
    typedef struct {
        logic [1:0] row;
        logic [3:0] col;
        logic [6:0] code;
        logic [1:0] kind;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    // Bench-side expectations
    int         ref_cnt   = 0;
    logic       exp_alarm = 1'b0;
    logic       pv1 = 1'b0, pv2 = 1'b0;
    logic [6:0] pc1 = 7'h20, pc2 = 7'h20, last_code = 7'h20;
    int         n_valid = 0;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request (or idle) for one cycle and check every output after
    // the edge against the 2-deep expected pipeline.
    task automatic applyStimulus(input logic req, input logic [1:0] row, input logic [3:0] col,
                                 input logic [6:0] exp);
        char_req = req;
        char_row = row;
        char_col = col;
        @(posedge clock);
        #1;
        if (reset) begin
            ref_cnt   = 0;
            pv1       = 1'b0;
            pv2       = 1'b0;
            pc1       = 7'h20;
            pc2       = 7'h20;
            last_code = 7'h20;
            exp_alarm = 1'b0;
        end else begin
            ref_cnt++;
            pv2 = pv1;
            pc2 = pc1;
            pv1 = req;
            pc1 = exp;
            if (pv2) last_code = pc2;
        end
        checkOutput("char_valid", 32'(char_valid), 32'(pv2));
        checkOutput("char_code", 32'(char_code), 32'(last_code));
        checkOutput("blink", 32'(blink), 32'((ref_cnt / 4) % 2));
        checkOutput("alarm", 32'(alarm), 32'(exp_alarm));
        if (char_valid === 1'b1) n_valid++;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'd0, 4'd0, 7'h20);
    endtask

    task automatic do_load();
        load = 1'b1;
        idle();
        load = 1'b0;
    endtask

    // Resolve a table entry against the blink phase and alarm at issue time
    function automatic logic [6:0] vec_expect(input vec_t v);
        logic blink_now;
        blink_now = ((ref_cnt / 4) % 2) == 1;
        case (v.kind)
            2'd1:    return blink_now ? 7'h3A : 7'h20;
            2'd2:    return (exp_alarm && !blink_now) ? 7'h20 : v.code;
            default: return v.code;
        endcase
    endfunction

    task automatic run_vectors(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            applyStimulus(1'b1, vecs[i].row, vecs[i].col, vec_expect(vecs[i]));
        end
        idle();
        idle();
    endtask

    task automatic add_row(input logic [1:0] r, input string s);
        for (int c = 0; c < 16; c++) begin
            vec_t v;
            v.row  = r;
            v.col  = 4'(c);
            v.code = 7'(s[c]);
            if (r == 2'd0 && (c == 2 || c == 5)) v.kind = 2'd1;
            else if (r == 2'd2)                  v.kind = 2'd2;
            else                                 v.kind = 2'd0;
            vecs.push_back(v);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; alarm_ack = 1'b0;
        hora = 0; min = 0; seg = 0; dia = 0; mes = 0; year = 0;
        horacrono = 0; mincrono = 0; segcrono = 0; AmPm = 0; format = 0;
        char_req = 0; char_row = 0; char_col = 0;

        add_row(2'd0, "11:59:30 PM     ");   //   0: 12h time
        add_row(2'd0, "23:59:30        ");   //  16: 24h time
        add_row(2'd1, "3?/07/16        ");   //  32: invalid date digit
        add_row(2'd2, "CRONO 00:00:00  ");   //  48: expired crono, flashing
        add_row(2'd2, "CRONO 12:34:56  ");   //  64: crono running
        add_row(2'd1, "00/00/00        ");   //  80: date after reset
        add_row(2'd0, "08:15:42 AM     ");   //  96: full grid
        add_row(2'd1, "31/12/99        ");
        add_row(2'd2, "CRONO 00:00:00  ");
        add_row(2'd3, "                ");

        // Reset state
        idle();
        idle();
        reset = 1'b0;

        // Basic time row, 12-hour format
        hora = 8'h11; min = 8'h59; seg = 8'h30; AmPm = 1'b1; format = 1'b1;
        do_load();
        run_vectors(0, 16);

        // 24-hour format and an out-of-range date digit
        format = 1'b0; hora = 8'h23; dia = 8'h3A; mes = 8'h07; year = 8'h16;
        do_load();
        run_vectors(16, 32);

        // Chronometer expiry, flashing row, acknowledge, zero-to-zero reload
        segcrono = 8'h05;
        do_load();
        segcrono = 8'h00;
        exp_alarm = 1'b1;
        do_load();
        run_vectors(48, 16);
        alarm_ack = 1'b1; exp_alarm = 1'b0;
        idle();
        alarm_ack = 1'b0;
        do_load();

        // Acknowledge in the same cycle as an expiring load: set wins
        segcrono = 8'h07;
        do_load();
        segcrono = 8'h00;
        alarm_ack = 1'b1; exp_alarm = 1'b1;
        do_load();
        exp_alarm = 1'b0;
        idle();
        alarm_ack = 1'b0;

        // Running chronometer row
        horacrono = 8'h12; mincrono = 8'h34; segcrono = 8'h56;
        do_load();
        run_vectors(64, 16);

        // Load concurrent with a request returns the old snapshot
        dia = 8'h28;
        load = 1'b1;
        applyStimulus(1'b1, 2'd1, 4'd1, 7'h3F);
        load = 1'b0;
        applyStimulus(1'b1, 2'd1, 4'd1, 7'h38);
        idle();
        idle();

        // Reset in the middle of a request burst, with the alarm set
        horacrono = 8'h00; mincrono = 8'h00; segcrono = 8'h01;
        do_load();
        segcrono = 8'h00; exp_alarm = 1'b1;
        do_load();
        applyStimulus(1'b1, 2'd1, 4'd0, 7'h32);
        applyStimulus(1'b1, 2'd1, 4'd1, 7'h38);
        applyStimulus(1'b1, 2'd1, 4'd2, 7'h2F);
        reset = 1'b1;
        applyStimulus(1'b1, 2'd1, 4'd3, 7'h30);
        applyStimulus(1'b1, 2'd1, 4'd4, 7'h37);
        reset = 1'b0;
        run_vectors(80, 16);

        // Full 64-cell sweep; hours bit 7 must be ignored
        hora = 8'h88; min = 8'h15; seg = 8'h42; dia = 8'h31; mes = 8'h12; year = 8'h99;
        horacrono = 8'h00; mincrono = 8'h00; segcrono = 8'h00; AmPm = 1'b0; format = 1'b1;
        do_load();
        n_valid = 0;
        run_vectors(96, 64);
        checkOutput("grid_valid_count", 32'(n_valid), 32'd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
